zigzag_varint_ser: RTL and testbench
====================================

// Module: zigzag_varint_ser
// PURPOSE
//  Streaming protobuf varint serializer with a built-in zigzag stage (sint32/sint64), the successor to the combinational zigzag unit.
//  Accepts one 64-bit field value per handshake, optionally zigzag-encodes it in 32- or 64-bit mode, then emits its
//  LEB128 varint bytes (1..10) over a valid/ready byte-lane stream, up to OUT_BYTES bytes per beat. Sits between field extraction and the wire-format packer.
// PARAMETERS
//  OUT_BYTES   1  varint bytes per output beat; legal 1..4
//  SIGN_EXT32  1  1: raw (non-zigzag) 32-bit values sign-extend to 64 (int32 rule); 0: zero-extend (uint32)
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             synchronous reset, active-high
//  in_valid   in   1             input value valid
//  in_ready   out  1             block accepts input this cycle
//  in_data    in   64            field value (32-bit modes use in_data[31:0])
//  in_zz      in   1             1: zigzag-encode before varint
//  in_is_32   in   1             1: 32-bit field semantics
//  out_valid  out  1             output beat valid
//  out_ready  in   1             downstream accepts beat
//  out_data   out  8*OUT_BYTES   varint bytes; lane 0 (bits 7:0) = earliest wire byte
//  out_cnt    out  $clog2(OUT_BYTES+1)  valid lanes this beat, 1..OUT_BYTES
//  out_last   out  1             final beat of this varint
//  out_len    out  4             total varint length 1..10, constant across all beats of a value
// BEHAVIOUR
//  Reset: state IDLE; out_valid=0, out_data=0, out_cnt=0, out_last=0, out_len=0; value/remaining regs cleared. in_ready=1 in cycle after reset.
//  Rst mid-stream: current varint abandoned, no further beats; next cycle IDLE.
//  Pre-encode V (64b) at acceptance:
//   zz & is_32 : V = zero-ext( (x[31:0]<<1) ^ {32{x[31]}} )
//   zz & !is_32: V = (x<<1) ^ {64{x[63]}}
//   !zz & is_32: V = SIGN_EXT32 ? sign-ext(x[31:0]) : zero-ext(x[31:0])
//   !zz & !is_32: V = x
//  Length n = max(1, ceil((msb_idx(V)+1)/7)); V=0 -> n=1, byte 0x00.
//  Byte k (0-based) = {k<n-1, V[7k+6:7k]}; byte 9 uses V[63] only, upper bits 0.
//  FSM: IDLE --(in_valid&in_ready)--> EMIT; EMIT --(out_valid&out_ready&out_last)--> IDLE, or EMIT again if a new value is accepted that same cycle.
//  in_ready = (state==IDLE) | (out_valid & out_ready & out_last): back-to-back values with no bubble; this is the only comb path (out_ready->in_ready).
//  Latency: value accepted at edge N -> first beat valid after edge N (visible cycle N+1). Throughput ceil(n/OUT_BYTES) beats per value.
//  Per beat: k = min(OUT_BYTES, remaining); out_cnt=k; lanes >= k driven 0; out_last = (remaining<=OUT_BYTES).
//  On out_valid&out_ready: remaining -= k, shift residual V right by 7k.
//  Stall: out_valid&!out_ready -> out_data/out_cnt/out_last/out_len held stable; out_valid never drops until accepted.
//  All out_* registered; no comb path from in_* to out_*.
//  in_valid while !in_ready: ignored, input held by producer (standard valid/ready).
// TESTING
//  T1 OUT_BYTES=1, zz=1,is_32=0, in=64'hFFFF_FFFF_FFFF_FFFF (-1) -> 1 beat 0x01, cnt=1, last=1, len=1.
//  T2 OUT_BYTES=1, zz=1,is_32=1, in[31:0]=32'h8000_0000 -> beats FF,FF,FF,FF,0F; last on 5th only; len=5.
//  T3 zz=0,is_32=0, in=300 -> OUT_BYTES=1: AC then 02 (last), len=2; OUT_BYTES=2: one beat data=16'h02AC, cnt=2, last.
//  T4 OUT_BYTES=4, zz=0,is_32=1,SIGN_EXT32=1, in[31:0]=32'hFFFF_FFFF -> 3 beats cnt 4,4,2: FFx9 then 01, lanes 2-3 of beat 3 = 0, len=10; SIGN_EXT32=0 -> FF,FF,FF,FF,0F, len=5.
//  T5 backpressure/back-to-back: out_ready low 3 cycles mid-T2 -> beat held unchanged; values 0 then 1 streamed with out_ready=1 -> beats 00,01 in consecutive cycles, in_ready high both.
//  T6 rst high during beat 3 of T4 -> next cycle out_valid=0, out_cnt=0, in_ready=1; following value 5 emits single beat 0x05.

Source files
------------

// File: rtl/zigzag_varint_ser.sv
// Streaming protobuf varint serializer with optional zigzag pre-encode.
// Emits LEB128 bytes over a valid/ready stream, up to OUT_BYTES per beat.
module zigzag_varint_ser #(
  parameter int unsigned OUT_BYTES  = 1,
  parameter bit          SIGN_EXT32 = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [63:0]                      in_data,
  input  logic                             in_zz,
  input  logic                             in_is_32,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [8*OUT_BYTES-1:0]           out_data,
  output logic [$clog2(OUT_BYTES+1)-1:0]   out_cnt,
  output logic                             out_last,
  output logic [3:0]                       out_len
);

  localparam int CW = $clog2(OUT_BYTES + 1);
  localparam int DW = 8 * OUT_BYTES;
  localparam logic [3:0] OB4 = 4'(OUT_BYTES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [63:0]   val_q, val_d;
  logic [3:0]    rem_q, rem_d;
  logic          ov_q, ov_d;
  logic [DW-1:0] od_q, od_d;
  logic [CW-1:0] oc_q, oc_d;
  logic          ol_q, ol_d;
  logic [3:0]    on_q, on_d;

  function automatic logic [63:0] pre_enc(
    input logic [63:0] x,
    input logic        zz,
    input logic        is32
  );
    logic [63:0] v;
    v = x;
    unique case (1'b1)
      (zz && is32):
        v = {32'd0, {x[30:0], 1'b0} ^ {32{x[31]}}};
      (zz && !is32):
        v = {x[62:0], 1'b0} ^ {64{x[63]}};
      (!zz && is32):
        v = SIGN_EXT32 ? {{32{x[31]}}, x[31:0]}
                       : {32'd0, x[31:0]};
      default:
        v = x;
    endcase
    return v;
  endfunction

  // Number of 7-bit groups up to the highest non-zero one; zero still needs one byte.
  function automatic logic [3:0] vlen(input logic [63:0] v);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 1; i < 10; i++) begin
      if ((v >> (7 * i)) != 64'd0) n = 4'(i + 1);
    end
    return n;
  endfunction

  function automatic logic [DW-1:0] beat_data(
    input logic [63:0] r,
    input logic [3:0]  rem
  );
    logic [DW-1:0] d;
    d = '0;
    for (int j = 0; j < int'(OUT_BYTES); j++) begin
      if (4'(j) < rem) begin
        d[8*j +: 7] = r[7*j +: 7];
        d[8*j + 7]  = (4'(j) + 4'd1) < rem;
      end
    end
    return d;
  endfunction

  logic          fire;
  logic          last_fire;
  logic          accept;
  logic [63:0]   acc_v;
  logic [3:0]    acc_n;
  logic [63:0]   src_v;
  logic [3:0]    src_rem;
  logic [3:0]    take;
  logic [DW-1:0] beat;

  assign fire      = ov_q & out_ready;
  assign last_fire = fire & ol_q;
  assign in_ready  = (state_q == IDLE) | last_fire;
  assign accept    = in_valid & in_ready;

  assign acc_v   = pre_enc(in_data, in_zz, in_is_32);
  assign acc_n   = vlen(acc_v);
  assign src_v   = accept ? acc_v : val_q;
  assign src_rem = accept ? acc_n : rem_q;
  assign take    = (src_rem > OB4) ? OB4 : src_rem;
  assign beat    = beat_data(src_v, src_rem);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    rem_d   = rem_q;
    ov_d    = ov_q;
    od_d    = od_q;
    oc_d    = oc_q;
    ol_d    = ol_q;
    on_d    = on_q;
    if (accept || (fire && !ol_q)) begin
      state_d = EMIT;
      ov_d    = 1'b1;
      od_d    = beat;
      oc_d    = CW'(take);
      ol_d    = src_rem <= OB4;
      val_d   = src_v >> (6'd7 * 6'(take));
      rem_d   = src_rem - take;
      if (accept) on_d = acc_n;
    end else if (last_fire) begin
      state_d = IDLE;
      ov_d    = 1'b0;
      od_d    = '0;
      oc_d    = '0;
      ol_d    = 1'b0;
      on_d    = 4'd0;
      val_d   = 64'd0;
      rem_d   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= 64'd0;
      rem_q   <= 4'd0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oc_q    <= '0;
      ol_q    <= 1'b0;
      on_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      rem_q   <= rem_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oc_q    <= oc_d;
      ol_q    <= ol_d;
      on_q    <= on_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_cnt   = oc_q;
  assign out_last  = ol_q;
  assign out_len   = on_q;

endmodule

// File: tb/tb_zigzag_varint_ser.sv
// Scoreboard bench for zigzag_varint_ser: directed corner values plus
// randomized values against a byte-level reference model.
module tb_zigzag_varint_ser;

  localparam int OB = 3;
  localparam bit SE = 1'b1;
  localparam int CW = $clog2(OB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = 64'd0;
  logic          in_zz = 1'b0;
  logic          in_is_32 = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [8*OB-1:0] out_data;
  logic [CW-1:0] out_cnt;
  logic          out_last;
  logic [3:0]    out_len;

  zigzag_varint_ser #(.OUT_BYTES(OB), .SIGN_EXT32(SE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_zz(in_zz), .in_is_32(in_is_32),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt),
    .out_last(out_last), .out_len(out_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*OB-1:0] data;
    logic [CW-1:0]   cnt;
    logic            last;
    logic [3:0]      len;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit force_rdy = 1'b0;
  bit hold_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    out_ready <= force_rdy ? 1'b1 :
                 hold_rdy  ? 1'b0 :
                 ($urandom_range(0, 3) != 0);

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: zigzag as arithmetic, then repeated 7-bit LEB128 division.
  function automatic void model(input logic [63:0] x, input logic zz,
                                input logic is32);
    logic [63:0] v;
    longint s;
    logic [7:0] bq[$];
    logic [7:0] b;
    int n;
    beat_t e;
    if (zz && is32) begin
      s = longint'($signed(x[31:0]));
      v = (s >= 0) ? 64'(2 * s) : 64'(-2 * s - 1);
    end else if (zz) begin
      s = $signed(x);
      v = (s >= 0) ? 64'(s) * 2 : 64'(-(s + 1)) * 2 + 64'd1;
    end else if (is32) begin
      v = SE ? 64'(longint'($signed(x[31:0]))) : {32'd0, x[31:0]};
    end else begin
      v = x;
    end
    do begin
      b = {1'b0, v[6:0]};
      v = v / 128;
      if (v != 0) b = b + 8'd128;
      bq.push_back(b);
    end while (v != 0);
    n = bq.size();
    for (int i = 0; i < n; i += OB) begin
      e.data = '0;
      e.cnt  = CW'((n - i < OB) ? n - i : OB);
      for (int j = 0; j < OB; j++)
        if (i + j < n) e.data[8*j +: 8] = bq[i + j];
      e.last = (i + OB >= n);
      e.len  = 4'(n);
      exp_q.push_back(e);
    end
  endfunction

  bit stall_chk = 1'b0;
  beat_t held;
  beat_t got;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      stall_chk = 1'b0;
    end else begin
      if (stall_chk) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(held.data));
        check("stall_cnt", 64'(out_cnt), 64'(held.cnt));
        check("stall_last", 64'(out_last), 64'(held.last));
        check("stall_len", 64'(out_len), 64'(held.len));
      end
      stall_chk = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %0h want none", out_data);
        end else begin
          got = exp_q.pop_front();
          check("data", 64'(out_data), 64'(got.data));
          check("cnt", 64'(out_cnt), 64'(got.cnt));
          check("last", 64'(out_last), 64'(got.last));
          check("len", 64'(out_len), 64'(got.len));
        end
      end else if (out_valid) begin
        stall_chk = 1'b1;
        held.data = out_data;
        held.cnt  = out_cnt;
        held.last = out_last;
        held.len  = out_len;
      end
    end
  end

  task automatic send(input logic [63:0] x, input logic zz,
                      input logic is32, output int acc);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    in_zz    = zz;
    in_is_32 = is32;
    #1;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready 0 want 1");
      in_valid = 1'b0;
      acc = -1;
    end else begin
      model(x, zz, is32);
      acc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  int c0, c1;
  logic [63:0] rx;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_cnt", 64'(out_cnt), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_len", 64'(out_len), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, c0);
    send(64'h0000_0000_8000_0000, 1'b1, 1'b1, c0);
    send(64'd300, 1'b0, 1'b0, c0);
    send(64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1, c0);
    send(64'h8000_0000_0000_0000, 1'b0, 1'b0, c0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, c0);
    send(64'd127, 1'b0, 1'b0, c0);
    send(64'd128, 1'b0, 1'b0, c0);
    drain();

    hold_rdy = 1'b1;
    send(64'h0000_0000_8000_0000, 1'b1, 1'b1, c0);
    repeat (4) @(negedge clk);
    hold_rdy = 1'b0;
    drain();

    force_rdy = 1'b1;
    @(negedge clk);
    send(64'd0, 1'b0, 1'b0, c0);
    send(64'd1, 1'b0, 1'b0, c1);
    check("b2b_gap", 64'(c1 - c0), 64'd1);
    drain();

    send(64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1, c0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_cnt", 64'(out_cnt), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    send(64'd5, 1'b0, 1'b0, c0);
    drain();
    force_rdy = 1'b0;

    for (int i = 0; i < 300; i++) begin
      rx = {$urandom, $urandom};
      rx = rx >> $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) rx = ~rx;
      send(rx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
